mem_wb_pipeline: RTL and testbench
==================================

Name: mem_wb_pipeline

Overview:
Parametrised back-end of the core: EX/MEM pipeline register, data-memory stage with a second read-only port, an optional extra memory-latency stage, MEM/WB register and writeback mux, all in one block. It accepts one ALU-stage result per cycle and presents register-file writeback plus forwarding buses to the decode/execute stages. It adds per-entry valid bits, global stall/flush, configurable read latency and forwarding outputs.

Parameters:
DATA_W, 24, datapath width
DEST_W, 4, destination register index width
ADDR_W, 18, memory address width; address = alu_result[ADDR_W-1:0]
MEM_DEPTH, 2**18, words of data memory; 1 <= MEM_DEPTH <= 2**ADDR_W
READ_LATENCY, 1, memory read latency in cycles; legal values 1 or 2

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  ALU-stage output holds a real instruction
writeback_enable  in  1  instruction writes the register file
mem_read_enable  in  1  instruction is a load
mem_write_enable  in  1  instruction is a store
instruction_dest  in  DEST_W  destination register
alu_result  in  DATA_W  ALU result / memory address
write_data  in  DATA_W  store data
stall  in  1  hold every pipeline register
flush  in  1  invalidate every in-flight entry
address_b  in  ADDR_W  port-B (display) read address
read_data_b  out  DATA_W  port-B read data, 1-cycle latency
writeback_enable_out  out  1  register-file write strobe
instruction_dest_out  out  DEST_W  register-file write index
writeback_data_out  out  DATA_W  register-file write data
fwd_mem_valid  out  1  EX/MEM entry forwardable (valid, wb, not load)
fwd_mem_dest  out  DEST_W  EX/MEM destination
fwd_mem_data  out  DATA_W  EX/MEM alu_result
mem_busy_load  out  1  a valid load is in EX/MEM or the latency stage (for hazard unit)

Behaviour:
- rst low (async): all valid bits, control bits, dest and data registers cleared; read_data_b = 0; all outputs 0. Memory contents not reset.
- Advance = !stall. On each rising edge with advance: EX/MEM <= inputs with valid = in_valid; downstream registers shift one stage. With stall: all registers, including RAM output holding registers, keep their values.
- flush (priority over stall): on the edge, every valid bit clears; data fields may stay. The incoming instruction is also dropped.
- Store: RAM write happens on the edge where a valid store leaves EX/MEM (advance=1, flush=0). It happens exactly once, however long the stall. Address >= MEM_DEPTH: write ignored.
- Load: RAM read issued on the same leave edge. Data is registered and held while stalled. Address >= MEM_DEPTH returns 0.
- READ_LATENCY=1: EX/MEM -> MEM/WB. READ_LATENCY=2: EX/MEM -> MEM2 -> MEM/WB, with RAM data registered again in MEM2.
- Latency from accept edge to writeback outputs: READ_LATENCY+1 edges.
- Writeback outputs come combinationally from MEM/WB:
  - writeback_enable_out = valid & wb_en
  - writeback_data_out = load ? ram data : alu_result
  - instruction_dest_out = dest, or 0 when not valid
- fwd_mem_*: from EX/MEM. fwd_mem_valid = valid & wb_en & !load.
- mem_busy_load: set for any valid load in EX/MEM or MEM2.
- Store followed by a load to the same address on the next cycle returns the new data.
- Port B is read-first: a same-edge port-A write to address_b returns the old word.
- Port B is unaffected by stall, flush and address range checks beyond the same rules (out of range reads 0).
- A store never asserts writeback_enable_out, even if the wb bit is set.

Decomposition:
- Package mem_wb_pkg holds:
  - stage-entry struct typedef (valid, wb_en, rd_en, wr_en, dest, alu_result, write_data)
  - default widths
  - a ZERO_ENTRY constant
- Sub-module: dp_ram, a true-dual-port inferred RAM with one write/read port A and one read port B, parametrised DATA_W/ADDR_W/MEM_DEPTH.

Test Plan:
- Reset mid-operation: stream three valid ALU ops, assert rst=0 between edges -> all outputs 0 immediately, and no writeback pulses after release until new input.
- Back-to-back store/load, READ_LATENCY=1: store 0xABCDEF to 0x00010, then load from 0x00010 to r5 -> 2 edges after the load is accepted: writeback_enable_out=1, dest=5, data=0xABCDEF.
- Stall on a store: store 0x000123 to 0x00004, stall for 3 cycles, then load -> returns 0x000123. A write counter in the bench sees exactly 1 RAM write.
- Flush during a load: load accepted, flush on the next edge -> no writeback pulse. Port B at 0x00004 still returns 0x000123.
- READ_LATENCY=2 with forwarding: ALU op r3 = 0x00007F -> fwd_mem_valid=1, fwd_mem_data=0x00007F one edge after accept. Writeback appears 3 edges after accept. A load into EX/MEM gives fwd_mem_valid=0 and mem_busy_load=1.
- Port-B collision and range: same edge, port-A write 0x111111 and port-B read of that address -> old value. Load from address >= MEM_DEPTH (MEM_DEPTH=1024, address 0x00400) -> data 0.

Source files
------------

// File: rtl/mem_wb_pkg.sv
// Shared types and default widths for the memory/writeback back-end.
package mem_wb_pkg;

  localparam int DEF_DATA_W = 24;
  localparam int DEF_DEST_W = 4;
  localparam int DEF_ADDR_W = 18;

  // Stage entry at the default widths; parametrised instances mirror this layout.
  typedef struct packed {
    logic                  valid;
    logic                  wb_en;
    logic                  rd_en;
    logic                  wr_en;
    logic [DEF_DEST_W-1:0] dest;
    logic [DEF_DATA_W-1:0] alu_result;
    logic [DEF_DATA_W-1:0] write_data;
  } entry_t;

  localparam entry_t ZERO_ENTRY = '0;

endpackage

// File: rtl/dp_ram.sv
// Dual-port data memory: port A read/write, port B read-only, both with a registered read.
module dp_ram #(
  parameter int DATA_W    = 24,
  parameter int ADDR_W    = 18,
  parameter int MEM_DEPTH = 2**18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_a_i,
  input  logic              we_a_i,
  input  logic [ADDR_W-1:0] addr_a_i,
  input  logic [DATA_W-1:0] wdata_a_i,
  output logic [DATA_W-1:0] rdata_a_o,
  input  logic [ADDR_W-1:0] addr_b_i,
  output logic [DATA_W-1:0] rdata_b_o
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  logic [DATA_W-1:0] mem [0:MEM_DEPTH-1];
  logic [DATA_W-1:0] rdata_a_q;
  logic [DATA_W-1:0] rdata_b_q;

  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return 33'(addr) < 33'(MEM_DEPTH);
  endfunction

  always_ff @(posedge clk) begin
    if (we_a_i && in_range(addr_a_i)) begin
      mem[addr_a_i[IDX_W-1:0]] <= wdata_a_i;
    end
  end

  // Both ports read the pre-write contents, so a same-edge collision returns the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      if (en_a_i) begin
        rdata_a_q <= in_range(addr_a_i) ? mem[addr_a_i[IDX_W-1:0]] : '0;
      end
      rdata_b_q <= in_range(addr_b_i) ? mem[addr_b_i[IDX_W-1:0]] : '0;
    end
  end

  assign rdata_a_o = rdata_a_q;
  assign rdata_b_o = rdata_b_q;

endmodule

// File: rtl/mem_wb_pipeline.sv
// EX/MEM register, data memory, optional second memory stage, MEM/WB register,
// writeback mux and EX/MEM forwarding for the core back-end.
module mem_wb_pipeline import mem_wb_pkg::*; #(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int DEST_W       = DEF_DEST_W,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int MEM_DEPTH    = 2**DEF_ADDR_W,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              writeback_enable,
  input  logic              mem_read_enable,
  input  logic              mem_write_enable,
  input  logic [DEST_W-1:0] instruction_dest,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] write_data,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] address_b,
  output logic [DATA_W-1:0] read_data_b,
  output logic              writeback_enable_out,
  output logic [DEST_W-1:0] instruction_dest_out,
  output logic [DATA_W-1:0] writeback_data_out,
  output logic              fwd_mem_valid,
  output logic [DEST_W-1:0] fwd_mem_dest,
  output logic [DATA_W-1:0] fwd_mem_data,
  output logic              mem_busy_load
);

  typedef struct packed {
    logic              valid;
    logic              wb_en;
    logic              rd_en;
    logic              wr_en;
    logic [DEST_W-1:0] dest;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] write_data;
  } exmem_t;

  // Past EX/MEM the store data is no longer needed.
  typedef struct packed {
    logic              valid;
    logic              wb_en;
    logic              rd_en;
    logic              wr_en;
    logic [DEST_W-1:0] dest;
    logic [DATA_W-1:0] alu_result;
  } tail_t;

  logic              advance;
  exmem_t            in_entry, exmem_q, exmem_d;
  tail_t             exmem_tail, memwb_src, memwb_q, memwb_d;
  logic [DATA_W-1:0] ram_rdata_a;
  logic [DATA_W-1:0] load_data;
  logic              mem2_busy;
  logic              ram_we;

  assign advance = !stall;

  assign in_entry = '{valid: in_valid, wb_en: writeback_enable, rd_en: mem_read_enable,
                      wr_en: mem_write_enable, dest: instruction_dest,
                      alu_result: alu_result, write_data: write_data};

  assign exmem_tail = '{valid: exmem_q.valid, wb_en: exmem_q.wb_en, rd_en: exmem_q.rd_en,
                        wr_en: exmem_q.wr_en, dest: exmem_q.dest,
                        alu_result: exmem_q.alu_result};

  // Flush overrides stall: valid bits drop even when the registers hold.
  always_comb begin
    exmem_d = exmem_q;
    if (advance) exmem_d = in_entry;
    if (flush)   exmem_d.valid = 1'b0;
    memwb_d = memwb_q;
    if (advance) memwb_d = memwb_src;
    if (flush)   memwb_d.valid = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  // A store commits only on the edge it leaves EX/MEM, so a long stall writes once.
  assign ram_we = advance && !flush && exmem_q.valid && exmem_q.wr_en;

  dp_ram #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_ram (
    .clk       (clk),
    .rst_n     (rst),
    .en_a_i    (advance),
    .we_a_i    (ram_we),
    .addr_a_i  (exmem_q.alu_result[ADDR_W-1:0]),
    .wdata_a_i (exmem_q.write_data),
    .rdata_a_o (ram_rdata_a),
    .addr_b_i  (address_b),
    .rdata_b_o (read_data_b)
  );

  generate
    if (READ_LATENCY == 2) begin : g_mem2
      tail_t             mem2_q, mem2_d;
      logic [DATA_W-1:0] rdata2_q, rdata2_d;

      always_comb begin
        mem2_d   = mem2_q;
        rdata2_d = rdata2_q;
        if (advance) begin
          mem2_d   = exmem_tail;
          rdata2_d = ram_rdata_a;
        end
        if (flush) mem2_d.valid = 1'b0;
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          mem2_q   <= '0;
          rdata2_q <= '0;
        end else begin
          mem2_q   <= mem2_d;
          rdata2_q <= rdata2_d;
        end
      end

      assign memwb_src = mem2_q;
      assign load_data = rdata2_q;
      assign mem2_busy = mem2_q.valid & mem2_q.rd_en;
    end else begin : g_mem1
      assign memwb_src = exmem_tail;
      assign load_data = ram_rdata_a;
      assign mem2_busy = 1'b0;
    end
  endgenerate

  assign writeback_enable_out = memwb_q.valid & memwb_q.wb_en & ~memwb_q.wr_en;
  assign instruction_dest_out = memwb_q.valid ? memwb_q.dest : '0;
  assign writeback_data_out   = memwb_q.rd_en ? load_data : memwb_q.alu_result;

  assign fwd_mem_valid = exmem_q.valid & exmem_q.wb_en & ~exmem_q.rd_en;
  assign fwd_mem_dest  = exmem_q.dest;
  assign fwd_mem_data  = exmem_q.alu_result;
  assign mem_busy_load = (exmem_q.valid & exmem_q.rd_en) | mem2_busy;

endmodule

// File: tb/tb_mem_wb_pipeline.sv
// Random and directed checks of two back-end instances (read latency 1 and 2) against a history model.
module tb_mem_wb_pipeline;

  localparam int DW    = 24;
  localparam int RW    = 4;
  localparam int AW    = 18;
  localparam int DEPTH = 1024;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid, writeback_enable, mem_read_enable, mem_write_enable;
  logic [RW-1:0] instruction_dest;
  logic [DW-1:0] alu_result, write_data;
  logic          stall, flush;
  logic [AW-1:0] address_b;

  logic [DW-1:0] rdb1, wbd1, fwdd1, rdb2, wbd2, fwdd2;
  logic [RW-1:0] dst1, fwdr1, dst2, fwdr2;
  logic          wbe1, fwdv1, busy1, wbe2, fwdv2, busy2;

  always #5 clk = ~clk;

  mem_wb_pipeline #(.DATA_W(DW), .DEST_W(RW), .ADDR_W(AW), .MEM_DEPTH(DEPTH), .READ_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .writeback_enable(writeback_enable),
    .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
    .instruction_dest(instruction_dest), .alu_result(alu_result), .write_data(write_data),
    .stall(stall), .flush(flush), .address_b(address_b), .read_data_b(rdb1),
    .writeback_enable_out(wbe1), .instruction_dest_out(dst1), .writeback_data_out(wbd1),
    .fwd_mem_valid(fwdv1), .fwd_mem_dest(fwdr1), .fwd_mem_data(fwdd1), .mem_busy_load(busy1));

  mem_wb_pipeline #(.DATA_W(DW), .DEST_W(RW), .ADDR_W(AW), .MEM_DEPTH(DEPTH), .READ_LATENCY(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .writeback_enable(writeback_enable),
    .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
    .instruction_dest(instruction_dest), .alu_result(alu_result), .write_data(write_data),
    .stall(stall), .flush(flush), .address_b(address_b), .read_data_b(rdb2),
    .writeback_enable_out(wbe2), .instruction_dest_out(dst2), .writeback_data_out(wbd2),
    .fwd_mem_valid(fwdv2), .fwd_mem_dest(fwdr2), .fwd_mem_data(fwdd2), .mem_busy_load(busy2));

  // Model: one history entry per advancing edge; an instruction sits RL entries back when it writes back.
  typedef struct {
    bit          valid, wb, rd, wr;
    logic [RW-1:0] dest;
    logic [DW-1:0] alu, wd, ld;
  } item_t;

  item_t         hist[$];
  logic [DW-1:0] ref_mem [int];
  logic [DW-1:0] pb_exp;
  bit            pb_chk;
  int            n_assert = 0;
  int            n_fail = 0;
  int            wr_count = 0;

  always @(posedge clk) if (rst && dut1.u_ram.we_a_i) wr_count++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    item_t b;
    b = '{default: '0};
    hist.delete();
    repeat (3) hist.push_back(b);
    pb_exp = '0;
    pb_chk = 1'b1;
  endtask

  task automatic model_edge();
    item_t it, b;
    int    la;
    b = '{default: '0};
    if (!rst) return;
    if (address_b < AW'(DEPTH)) begin
      pb_chk = ref_mem.exists(int'(address_b));
      if (pb_chk) pb_exp = ref_mem[int'(address_b)];
    end else begin
      pb_chk = 1'b1;
      pb_exp = '0;
    end
    if (flush) begin
      if (!stall) hist.push_back(b);
      for (int i = hist.size() - 3; i < hist.size(); i++) begin
        it = hist[i];
        it.valid = 1'b0;
        hist[i] = it;
      end
    end else if (!stall) begin
      it = hist[hist.size() - 1];
      la = int'(it.alu[AW-1:0]);
      if (it.valid && it.wr && la < DEPTH) ref_mem[la] = it.wd;
      if (it.valid && it.rd) begin
        it.ld = (la < DEPTH) ? ref_mem[la] : '0;
        hist[hist.size() - 1] = it;
      end
      it.valid = in_valid; it.wb = writeback_enable; it.rd = mem_read_enable;
      it.wr = mem_write_enable; it.dest = instruction_dest; it.alu = alu_result;
      it.wd = write_data; it.ld = '0;
      hist.push_back(it);
    end
  endtask

  task automatic check_wb(input string tag, input item_t m, input logic wbe,
                          input logic [RW-1:0] dst, input logic [DW-1:0] dat);
    bit e;
    e = m.valid & m.wb & !m.wr;
    chk({tag, "_wbe"}, 32'(wbe), 32'(e));
    chk({tag, "_dest"}, 32'(dst), m.valid ? 32'(m.dest) : 32'd0);
    if (e) chk({tag, "_wbdata"}, 32'(dat), m.rd ? 32'(m.ld) : 32'(m.alu));
  endtask

  task automatic check_outputs();
    item_t ex, pre, m2;
    bit    fv;
    int    n;
    n   = hist.size();
    ex  = hist[n-1];
    pre = hist[n-2];
    m2  = hist[n-3];
    check_wb("rl1", pre, wbe1, dst1, wbd1);
    check_wb("rl2", m2, wbe2, dst2, wbd2);
    fv = ex.valid & ex.wb & !ex.rd;
    chk("rl1_fwdv", 32'(fwdv1), 32'(fv));
    chk("rl2_fwdv", 32'(fwdv2), 32'(fv));
    if (fv) begin
      chk("rl1_fwd_dest", 32'(fwdr1), 32'(ex.dest));
      chk("rl1_fwd_data", 32'(fwdd1), 32'(ex.alu));
      chk("rl2_fwd_data", 32'(fwdd2), 32'(ex.alu));
    end
    chk("rl1_busy", 32'(busy1), 32'(ex.valid & ex.rd));
    chk("rl2_busy", 32'(busy2), 32'((ex.valid & ex.rd) | (pre.valid & pre.rd)));
    if (pb_chk) begin
      chk("rl1_portb", 32'(rdb1), 32'(pb_exp));
      chk("rl2_portb", 32'(rdb2), 32'(pb_exp));
    end
  endtask

  task automatic check_reset();
    chk("rst_wbe1", 32'(wbe1), 0);  chk("rst_dst1", 32'(dst1), 0);  chk("rst_wbd1", 32'(wbd1), 0);
    chk("rst_fwdv1", 32'(fwdv1), 0); chk("rst_fwdd1", 32'(fwdd1), 0); chk("rst_busy1", 32'(busy1), 0);
    chk("rst_rdb1", 32'(rdb1), 0);  chk("rst_fwdr1", 32'(fwdr1), 0);
    chk("rst_wbe2", 32'(wbe2), 0);  chk("rst_dst2", 32'(dst2), 0);  chk("rst_wbd2", 32'(wbd2), 0);
    chk("rst_fwdv2", 32'(fwdv2), 0); chk("rst_busy2", 32'(busy2), 0); chk("rst_rdb2", 32'(rdb2), 0);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic drive(input bit v, input bit wb, input bit rd, input bit wr, input logic [RW-1:0] d,
                       input logic [DW-1:0] alu, input logic [DW-1:0] wd, input bit st, input bit fl);
    in_valid = v; writeback_enable = wb; mem_read_enable = rd; mem_write_enable = wr;
    instruction_dest = d; alu_result = alu; write_data = wd; stall = st; flush = fl;
  endtask

  task automatic alu_op(input logic [RW-1:0] d, input logic [DW-1:0] v);
    drive(1, 1, 0, 0, d, v, DW'($urandom), 0, 0);
    cycle();
  endtask

  task automatic ld_op(input logic [RW-1:0] d, input logic [DW-1:0] a);
    drive(1, 1, 1, 0, d, a, DW'($urandom), 0, 0);
    cycle();
  endtask

  task automatic st_op(input logic [DW-1:0] a, input logic [DW-1:0] v, input bit wb);
    drive(1, wb, 0, 1, RW'($urandom), a, v, 0, 0);
    cycle();
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, '0, '0, '0, 0, 0);
    cycle();
  endtask

  function automatic logic [DW-1:0] rand_addr();
    if ($urandom_range(0, 9) == 0) return {6'($urandom), 18'(DEPTH + $urandom_range(0, 63))};
    return {6'($urandom), 18'($urandom_range(0, 31))};
  endfunction

  initial begin
    logic [DW-1:0] old;
    int op;
    model_reset();
    drive(0, 0, 0, 0, '0, '0, '0, 0, 0);
    address_b = '0;
    #2;
    check_reset();
    @(posedge clk);
    #1 rst = 1'b1;

    for (int a = 0; a < 32; a++) st_op(DW'(a), DW'($urandom), 1'($urandom));
    idle();

    // Store then load to the same address on the next cycle.
    st_op(24'h000010, 24'hABCDEF, 0);
    ld_op(4'd5, 24'h000010);
    idle();
    chk("st_ld_wbe", 32'(wbe1), 1);
    chk("st_ld_dest", 32'(dst1), 5);
    chk("st_ld_data", 32'(wbd1), 32'hABCDEF);
    repeat (3) idle();

    // Store held by a three-cycle stall commits exactly once.
    wr_count = 0;
    st_op(24'h000004, 24'h000123, 1);
    repeat (3) begin
      drive(1, 1, 0, 1, 4'd2, 24'h000004, 24'h000999, 1, 0);
      cycle();
    end
    ld_op(4'd6, 24'h000004);
    idle();
    chk("stall_ld_data", 32'(wbd1), 32'h123);
    chk("stall_ld_wbe", 32'(wbe1), 1);
    idle();
    chk("stall_wr_count", 32'(wr_count), 1);
    repeat (3) idle();

    // Flush right after a load is accepted drops it.
    ld_op(4'd7, 24'h000004);
    address_b = 18'h00004;
    drive(1, 1, 0, 0, 4'd8, 24'h000055, '0, 0, 1);
    cycle();
    chk("flush_portb", 32'(rdb1), 32'h123);
    repeat (2) begin
      idle();
      chk("flush_wbe1", 32'(wbe1), 0);
      chk("flush_wbe2", 32'(wbe2), 0);
    end

    // Forwarding and three-edge writeback with the extra memory stage.
    alu_op(4'd3, 24'h00007F);
    chk("fwd_valid2", 32'(fwdv2), 1);
    chk("fwd_dest2", 32'(fwdr2), 3);
    chk("fwd_data2", 32'(fwdd2), 32'h7F);
    idle();
    chk("rl2_early_wbe", 32'(wbe2), 0);
    idle();
    chk("rl2_wbe", 32'(wbe2), 1);
    chk("rl2_dest", 32'(dst2), 3);
    chk("rl2_data", 32'(wbd2), 32'h7F);
    ld_op(4'd4, 24'h000010);
    chk("ld_fwd_valid2", 32'(fwdv2), 0);
    chk("ld_busy2", 32'(busy2), 1);
    idle();
    chk("ld_busy2_mem2", 32'(busy2), 1);
    chk("ld_busy1_gone", 32'(busy1), 0);
    repeat (2) idle();

    // Port-B read of the address being written on the same edge returns the old word.
    old = ref_mem[8];
    address_b = 18'h00008;
    st_op(24'h000008, 24'h111111, 0);
    idle();
    chk("collide_old", 32'(rdb1), 32'(old));
    idle();
    chk("collide_new", 32'(rdb1), 32'h111111);

    // Out-of-range load and port-B read return zero.
    address_b = 18'h00400;
    ld_op(4'd9, 24'h000400);
    idle();
    chk("oor_wbe", 32'(wbe1), 1);
    chk("oor_data", 32'(wbd1), 0);
    chk("oor_portb", 32'(rdb1), 0);

    for (int i = 0; i < 400; i++) begin
      op = $urandom_range(0, 2);
      address_b = ($urandom_range(0, 7) == 0) ? AW'(DEPTH + $urandom_range(0, 15)) : AW'($urandom_range(0, 31));
      drive($urandom_range(0, 4) != 0, 1'($urandom), op == 1, op == 2, RW'($urandom),
            (op == 0) ? DW'($urandom) : rand_addr(), DW'($urandom),
            $urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0);
      if (op == 1) writeback_enable = ($urandom_range(0, 5) != 0);
      cycle();
    end
    repeat (3) idle();

    // Asynchronous reset in the middle of a stream.
    alu_op(4'd1, 24'h000011);
    alu_op(4'd2, 24'h000022);
    alu_op(4'd3, 24'h000033);
    rst = 1'b0;
    #1;
    check_reset();
    model_reset();
    cycle();
    rst = 1'b1;
    repeat (4) begin
      idle();
      chk("post_rst_wbe1", 32'(wbe1), 0);
      chk("post_rst_wbe2", 32'(wbe2), 0);
    end
    alu_op(4'd12, 24'h000ABC);
    repeat (2) idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
